// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seven_seg_scan_ctrl_pkg;

   typedef enum logic {
      DARK = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] BLANK_SEG  = 7'b1111111;
   localparam logic [3:0] BLANK_AN   = 4'b1111;

endpackage

// File: rtl/seven_seg_scan_ctrl_dec.sv
// Team hex-to-seven-segment decoder (active-low {g,f,e,d,c,b,a}).
module bcd_to_7segment
   import seven_seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg,
   output logic [3:0] an
);

   always_comb begin
      seg = BLANK_SEG;
      an  = 4'b1110;
      case (bcd)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = BLANK_SEG;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed four-digit display driver with guard blanking and a
// frame-synchronous shadow register so a new digit set never tears mid-frame.
module seven_seg_scan_ctrl
   import seven_seg_scan_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [15:0] digits_in,
   input  logic [3:0]  blank_in,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done,
   output scan_state_t dbg_state
);

   localparam int            CW        = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

   scan_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [1:0]    idx_q;
   logic          pending_q;
   logic [15:0]   shadow_digits_q, active_digits_q;
   logic [3:0]    shadow_blank_q, active_blank_q;
   logic [6:0]    seg_q, seg_d, glyph;
   logic [3:0]    an_q, an_d, dec_an_unused;
   logic          frame_done_q;
   logic          scanning, slot_end, wrap, handshake, commit, show;

   always_comb begin
      state_d = state_q;
      case (state_q)
         DARK:    if (enable)  state_d = SCAN;
         SCAN:    if (!enable) state_d = DARK;
         default: state_d = DARK;
      endcase
   end

   // Valid/ready: a transfer happens on any rising edge where load_valid and
   // load_ready are both high; while ready is low the source holds its data.
   assign load_ready = ~pending_q & ~rst;
   assign handshake  = load_valid & load_ready;

   assign scanning = (state_q == SCAN) && enable;
   assign slot_end = scanning && (cnt_q == CNT_LAST);
   assign wrap     = slot_end && (idx_q == 2'd3);
   // While dark nothing is visible, so a pending set can be promoted at once.
   assign commit   = pending_q && (wrap || (state_q == DARK));

   bcd_to_7segment u_dec (
      .bcd (active_digits_q[{idx_q, 2'b00} +: 4]),
      .seg (glyph),
      .an  (dec_an_unused)
   );

   always_comb begin
      show = scanning && !active_blank_q[idx_q] && (cnt_q >= CNT_GUARD);
      an_d  = show ? ~(4'b0001 << idx_q) : BLANK_AN;
      seg_d = show ? glyph : BLANK_SEG;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= DARK;
         cnt_q           <= '0;
         idx_q           <= '0;
         pending_q       <= 1'b0;
         shadow_digits_q <= '0;
         shadow_blank_q  <= '0;
         active_digits_q <= '0;
         active_blank_q  <= BLANK_AN;
         an_q            <= BLANK_AN;
         seg_q           <= BLANK_SEG;
         frame_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= wrap;
         if (scanning) begin
            if (slot_end) begin
               cnt_q <= '0;
               idx_q <= idx_q + 2'd1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
            idx_q <= '0;
         end
         // Commit reads the old shadow even if a capture lands on the same edge.
         if (commit) begin
            active_digits_q <= shadow_digits_q;
            active_blank_q  <= shadow_blank_q;
         end
         if (handshake) begin
            shadow_digits_q <= digits_in;
            shadow_blank_q  <= blank_in;
         end
         pending_q <= handshake | (pending_q & ~commit);
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scenario bench for seven_seg_scan_ctrl at REFRESH_DIV=4, GUARD=1.
module tb_seven_seg_scan_ctrl;
   import seven_seg_scan_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [15:0] digits_in = '0;
   logic [3:0]  blank_in = '0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;
   scan_state_t dbg_state;

   int errors = 0;
   int checks = 0;
   int scan_s = 0;
   logic [11:0] exp_q[$];
   logic [11:0] exp_v, got_v;

   seven_seg_scan_ctrl #(.REFRESH_DIV(4), .GUARD(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .digits_in  (digits_in),
      .blank_in   (blank_in),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] glyph_of(input logic [3:0] c);
      case (c)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   // Expected {frame_done, an, seg} for n scan cycles: 4 cycles per slot,
   // first cycle of each slot blanked, frame_done seen after the 16th cycle.
   task automatic expect_cycles(input logic [15:0] d, input logic [3:0] b, input int n);
      for (int k = 0; k < n; k++) begin
         int dig, pos;
         logic fd;
         dig = (scan_s / 4) % 4;
         pos = scan_s % 4;
         fd  = ((scan_s % 16) == 15);
         if (pos == 0 || b[dig]) exp_q.push_back({fd, 4'b1111, 7'b1111111});
         else exp_q.push_back({fd, ~(4'b0001 << dig), glyph_of(d[dig*4 +: 4])});
         scan_s++;
      end
   endtask

   task automatic expect_dark(input int n);
      for (int k = 0; k < n; k++) exp_q.push_back({1'b0, 4'b1111, 7'b1111111});
      scan_s = 0;
   endtask

   task automatic pop_exp();
      if (exp_q.size() != 0) exp_v = exp_q.pop_front();
      else exp_v = 'x;
      got_v = {frame_done, an, seg};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({frame_done, an, seg} !== {1'b0, 4'b1111, 7'b1111111}) begin
         errors++;
         $display("FAIL reset_outputs got %b/%b/%b exp 0/1111/1111111", frame_done, an, seg);
      end
      checks++;
      if (load_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b exp 0", load_ready);
      end
      checks++;
      if (dbg_state !== DARK) begin
         errors++; $display("FAIL reset_state got %0d exp DARK", dbg_state);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (load_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready got %b exp 1", load_ready);
      end
   endtask

   task automatic test_first_load();
      expect_dark(3);
      expect_cycles(16'h4321, 4'b0000, 16);
      for (int i = 0; i < 19; i++) begin
         if (i == 0) begin load_valid = 1'b1; digits_in = 16'h4321; blank_in = 4'b0000; end
         if (i == 1) load_valid = 1'b0;
         if (i == 2) enable = 1'b1;
         tick();
         pop_exp();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL first_load[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
         if (i < 2) begin
            checks++;
            if (load_ready !== (i == 1)) begin
               errors++; $display("FAIL first_load_ready[%0d] got %b exp %b", i, load_ready, i == 1);
            end
         end
         if (i == 3) begin
            checks++;
            if (dbg_state !== SCAN) begin
               errors++; $display("FAIL scan_state got %0d exp SCAN", dbg_state);
            end
         end
      end
   endtask

   task automatic test_busy_load();
      expect_cycles(16'h4321, 4'b0000, 16);
      expect_cycles(16'h9A07, 4'b0000, 16);
      for (int i = 0; i < 32; i++) begin
         if (i == 0) begin load_valid = 1'b1; digits_in = 16'h9A07; end
         else if (i < 16) digits_in = 16'h8888;
         else load_valid = 1'b0;
         tick();
         pop_exp();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL busy_load[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
         if (i < 16) begin
            checks++;
            if (load_ready !== (i == 15)) begin
               errors++; $display("FAIL busy_ready[%0d] got %b exp %b", i, load_ready, i == 15);
            end
         end
      end
   endtask

   task automatic test_mid_frame_load();
      expect_cycles(16'h9A07, 4'b0000, 16);
      expect_cycles(16'hFEDC, 4'b0000, 16);
      for (int i = 0; i < 32; i++) begin
         if (i == 5) begin load_valid = 1'b1; digits_in = 16'hFEDC; end
         if (i == 6) load_valid = 1'b0;
         tick();
         pop_exp();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL mid_frame[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
      end
   endtask

   task automatic test_blank_mask();
      int fd_count;
      fd_count = 0;
      expect_cycles(16'hFEDC, 4'b0000, 16);
      expect_cycles(16'h2580, 4'b0100, 32);
      for (int i = 0; i < 48; i++) begin
         if (i == 0) begin load_valid = 1'b1; digits_in = 16'h2580; blank_in = 4'b0100; end
         if (i == 1) begin load_valid = 1'b0; blank_in = 4'b0000; end
         tick();
         pop_exp();
         if (frame_done === 1'b1) fd_count++;
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL blank_mask[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
      end
      checks++;
      if (fd_count != 3) begin
         errors++; $display("FAIL frame_done_count got %0d exp 3", fd_count);
      end
   endtask

   task automatic test_enable_toggle();
      expect_cycles(16'h2580, 4'b0100, 6);
      expect_dark(4);
      expect_cycles(16'h1357, 4'b0000, 8);
      for (int i = 0; i < 18; i++) begin
         if (i == 6) enable = 1'b0;
         if (i == 7) begin load_valid = 1'b1; digits_in = 16'h1357; blank_in = 4'b0000; end
         if (i == 8) load_valid = 1'b0;
         if (i == 9) enable = 1'b1;
         tick();
         pop_exp();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL enable_toggle[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
         if (i == 7 || i == 8) begin
            checks++;
            if (load_ready !== (i == 8)) begin
               errors++; $display("FAIL dark_commit_ready[%0d] got %b exp %b", i, load_ready, i == 8);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      expect_cycles(16'h1357, 4'b0000, 2);
      expect_dark(3);
      expect_cycles(16'h0000, 4'b1111, 16);
      for (int i = 0; i < 21; i++) begin
         if (i == 0) begin load_valid = 1'b1; digits_in = 16'h8642; end
         if (i == 1) load_valid = 1'b0;
         if (i == 2) rst = 1'b1;
         if (i == 4) rst = 1'b0;
         tick();
         pop_exp();
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_mid[%0d] got %b/%b/%b exp %b/%b/%b", i,
                     got_v[11], got_v[10:7], got_v[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
         end
         if (i >= 2) begin
            checks++;
            if (load_ready !== (i >= 4)) begin
               errors++; $display("FAIL reset_mid_ready[%0d] got %b exp %b", i, load_ready, i >= 4);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_load();
      test_busy_load();
      test_mid_frame_load();
      test_blank_mask();
      test_enable_toggle();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
